fpu_issue_ctrl: RTL and testbench

//  Front-end issue stage of the 8-bit FPU, directly upstream of Exception_Module and the arithmetic core.
//  - Accepts one operation (op, a, b) over a valid/ready handshake and registers the operands.
//  - Drives the registered operands to Exception_Module and samples its exception flag.
//  - If the flag is set, bypasses the core and returns canned NaN; otherwise starts the core and waits for done.
//  - Presents the result downstream over a valid/ready handshake and keeps a sticky exception status bit.

---
 rtl/fpu_issue_ctrl_pkg.sv | 15 +
 rtl/fpu_issue_ctrl_watchdog.sv | 18 +
 rtl/fpu_issue_ctrl.sv | 101 ++++++++++
 tb/tb_fpu_issue_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_issue_ctrl_pkg: shared op codes, special FP8 values and issue-stage state encodings
// Format is 1 sign, 4 exponent, 3 mantissa bits. The state encodings are shared with the core control.
package fpu_issue_ctrl_pkg;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;
  localparam logic [7:0] FP_PLUS_INF  = 8'h78;
  localparam logic [7:0] FP_MINUS_INF = 8'hF8;
  localparam logic [7:0] FP_NAN       = 8'h7C;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
endpackage

// File: rtl/fpu_issue_ctrl_watchdog.sv
// fpu_watchdog: EXEC-phase cycle counter that flags expiry on the LIMIT-th consecutive cycle of run
// Ports: clk, rst_n (async active-low), run (in EXEC), expired (high in the LIMIT-th run cycle).
// The counter restarts whenever run drops, so every EXEC entry begins counting from zero.
module fpu_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= run ? cnt + 1'b1 : '0;
  assign expired = run && cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: FPU issue stage - registers operands, checks exceptions, runs the core, returns the result
// Optional macro FPU_TIMEOUT_EN: adds the EXEC watchdog and the sticky_tmo output.
// Ports: in_valid/in_ready/in_op/in_a/in_b request; opnd_* registered operands to the exception check and core;
//        exc_flag from the exception check; core_start/core_done/core_result core handshake;
//        out_valid/out_ready/out_result/out_exc response; sticky_exc (+sticky_tmo) status, clr_sticky clear.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] NAN_CODE       = FP_NAN,
  parameter int                TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [1:0]        opnd_op,
  output logic [DATA_W-1:0] opnd_a,
  output logic [DATA_W-1:0] opnd_b,
  input  logic              exc_flag,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_exc,
  output logic              sticky_exc,
  input  logic              clr_sticky
`ifdef FPU_TIMEOUT_EN
  ,output logic             sticky_tmo
`endif
);
  logic [1:0] state;
  logic       tmo;
  logic       tmo_fire;
  logic       exc_set;
`ifdef FPU_TIMEOUT_EN
  fpu_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == S_EXEC),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif
  // a core_done on the expiry cycle takes priority over the timeout
  assign tmo_fire   = state == S_EXEC && !core_done && tmo;
  assign exc_set    = (state == S_CHECK && exc_flag) || tmo_fire;
  assign in_ready   = state == S_IDLE;
  assign out_valid  = state == S_RESP;
  assign core_start = state == S_CHECK && !exc_flag;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      opnd_op    <= '0;
      opnd_a     <= '0;
      opnd_b     <= '0;
      out_result <= '0;
      out_exc    <= 1'b0;
      sticky_exc <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (in_valid) begin
            opnd_op <= in_op;
            opnd_a  <= in_a;
            opnd_b  <= in_b;
            state   <= S_CHECK;
          end
        S_CHECK:
          if (exc_flag) begin
            out_result <= NAN_CODE;
            out_exc    <= 1'b1;
            state      <= S_RESP;
          end else state <= S_EXEC;
        S_EXEC:
          if (core_done) begin
            out_result <= core_result;
            out_exc    <= 1'b0;
            state      <= S_RESP;
          end else if (tmo_fire) begin
            out_result <= NAN_CODE;
            out_exc    <= 1'b1;
            state      <= S_RESP;
          end
        S_RESP: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      sticky_exc <= exc_set || (sticky_exc && !clr_sticky);
    end
`ifdef FPU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sticky_tmo <= 1'b0;
    else sticky_tmo <= tmo_fire || (sticky_tmo && !clr_sticky);
`endif
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed self-checking bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;
  localparam int T = 64;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = '0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [1:0] opnd_op;
  logic [7:0] opnd_a;
  logic [7:0] opnd_b;
  logic       exc_flag = 1'b0;
  logic       core_start;
  logic       core_done = 1'b0;
  logic [7:0] core_result = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic       out_exc;
  logic       sticky_exc;
  logic       clr_sticky = 1'b0;
`ifdef FPU_TIMEOUT_EN
  logic       sticky_tmo;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fpu_issue_ctrl #(.DATA_W(8), .NAN_CODE(8'h7C), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .opnd_op     (opnd_op),
    .opnd_a      (opnd_a),
    .opnd_b      (opnd_b),
    .exc_flag    (exc_flag),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_exc     (out_exc),
    .sticky_exc  (sticky_exc),
    .clr_sticky  (clr_sticky)
`ifdef FPU_TIMEOUT_EN
    ,.sticky_tmo (sticky_tmo)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic exc);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    exc_flag = exc;
    tick();
    in_valid = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_sticky", sticky_exc, 0);
    chk("rst_core_start", core_start, 0);
    rst_n = 1'b1;
    tick();
    // 1: exception path
    accept(OP_ADD, FP_PLUS_INF, 8'h00, 1'b1);
    chk("t1_opnd_a", opnd_a, 8'h78);
    chk("t1_in_ready_check", in_ready, 0);
    chk("t1_no_start", core_start, 0);
    chk("t1_not_valid_yet", out_valid, 0);
    tick();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_result", out_result, 8'h7C);
    chk("t1_out_exc", out_exc, 1);
    chk("t1_sticky", sticky_exc, 1);
    out_ready = 1'b1;
    exc_flag = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("t1_drop_valid", out_valid, 0);
    chk("t1_in_ready", in_ready, 1);
    // 2: core path, done 3 cycles after start
    accept(OP_MUL, 8'h38, 8'h40, 1'b0);
    chk("t2_start", core_start, 1);
    chk("t2_opnd_op", opnd_op, OP_MUL);
    chk("t2_opnd_b", opnd_b, 8'h40);
    tick();
    chk("t2_start_once", core_start, 0);
    chk("t2_exec_not_valid", out_valid, 0);
    tick();
    tick();
    core_done = 1'b1;
    core_result = 8'h48;
    tick();
    core_done = 1'b0;
    core_result = 8'h00;
    chk("t2_out_valid", out_valid, 1);
    chk("t2_result", out_result, 8'h48);
    chk("t2_out_exc", out_exc, 0);
    // 3: backpressure in RESP with a competing request
    in_valid = 1'b1;
    in_op = OP_DIV;
    in_a = 8'h11;
    in_b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_valid_hold", out_valid, 1);
      chk("t3_result_hold", out_result, 8'h48);
      chk("t3_exc_hold", out_exc, 0);
      chk("t3_in_ready", in_ready, 0);
      chk("t3_opnd_a_hold", opnd_a, 8'h38);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_consumed", out_valid, 0);
    // 4: reset during EXEC, stale core_done afterwards
    accept(OP_SUB, 8'h30, 8'h30, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", out_valid, 0);
    chk("t4_rst_in_ready", in_ready, 1);
    chk("t4_rst_opnd_a", opnd_a, 0);
    chk("t4_rst_sticky", sticky_exc, 0);
    #2;
    rst_n = 1'b1;
    core_done = 1'b1;
    core_result = 8'h55;
    tick();
    core_done = 1'b0;
    chk("t4_ignored_valid", out_valid, 0);
    chk("t4_ignored_result", out_result, 0);
    chk("t4_in_ready", in_ready, 1);
    // 5: sticky set beats clear in the same cycle
    accept(OP_DIV, 8'h38, 8'h00, 1'b1);
    clr_sticky = 1'b1;
    tick();
    chk("t5_set_wins", sticky_exc, 1);
    tick();
    clr_sticky = 1'b0;
    chk("t5_cleared", sticky_exc, 0);
    out_ready = 1'b1;
    exc_flag = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("t5_idle", in_ready, 1);
`ifdef FPU_TIMEOUT_EN
    // 6: watchdog expiry with no core_done
    accept(OP_MUL, 8'h38, 8'h38, 1'b0);
    tick();
    for (int i = 1; i < T; i++) begin
      tick();
      chk("t6_still_exec", out_valid, 0);
    end
    tick();
    chk("t6_timeout_valid", out_valid, 1);
    chk("t6_timeout_result", out_result, 8'h7C);
    chk("t6_timeout_exc", out_exc, 1);
    chk("t6_sticky_tmo", sticky_tmo, 1);
    chk("t6_sticky_exc", sticky_exc, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
